// File: rtl/apb_deco_pkg.sv
// rtl/apb_deco_pkg.sv - shared state encoding, bus width and slot helper for the APB3 N-port decoder
package apb_deco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } t_deco_st;

  localparam int C_APB_DW = 32;

  // A slot is mapped only if an MI port exists for it
  function automatic logic f_slot_valid(input int slot, input int num_mi);
    return (slot >= 0) && (slot < num_mi);
  endfunction

endpackage

// File: rtl/apb_deco_timer.sv
// rtl/apb_deco_timer.sv - ACCESS-phase cycle counter, used only when APB_DECO_TIMEOUT_EN is defined
module apb_deco_timer #(
  parameter int P_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(P_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear on the way into ACCESS, count every ACCESS cycle
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The edge that would bring the count to P_TIMEOUT ends the access
  assign expire = run && (cnt_q == CW'(P_TIMEOUT - 1));

endmodule

// File: rtl/apb3_deco_nport.sv
// rtl/apb3_deco_nport.sv - APB3 1-to-N decoder with registered MI launch; APB_DECO_TIMEOUT_EN adds an access timeout
module apb3_deco_nport
  import apb_deco_pkg::*;
#(
  parameter int P_NUM_MI  = 5,
  parameter int P_SEL_LSB = 12,
  parameter int P_SEL_W   = 4,
  parameter int P_MI_AW   = 12,
  parameter int P_TIMEOUT = 255
) (
  input  logic                         i_clk_si,
  input  logic                         i_rst_si,
  input  logic                         i_si_psel,
  input  logic                         i_si_penable,
  input  logic                         i_si_pwrite,
  input  logic [31:0]                  i_si_paddr,
  input  logic [C_APB_DW-1:0]          i_si_pwdata,
  output logic [C_APB_DW-1:0]          o_si_prdata,
  output logic                         o_si_pready,
  output logic                         o_si_pslverr,
  output logic [P_NUM_MI-1:0]          o_mi_psel,
  output logic                         o_mi_penable,
  output logic                         o_mi_pwrite,
  output logic [P_MI_AW-1:0]           o_mi_paddr,
  output logic [C_APB_DW-1:0]          o_mi_pwdata,
  input  logic [P_NUM_MI*C_APB_DW-1:0] i_mi_prdata,
  input  logic [P_NUM_MI-1:0]          i_mi_pready,
  input  logic [P_NUM_MI-1:0]          i_mi_pslverr,
  output logic                         o_timeout
);

  t_deco_st               state_q, state_d;
  logic [C_APB_DW-1:0]    si_prdata_q, si_prdata_d;
  logic                   si_pready_q, si_pready_d;
  logic                   si_pslverr_q, si_pslverr_d;
  logic [P_NUM_MI-1:0]    mi_psel_q, mi_psel_d;
  logic                   mi_penable_q, mi_penable_d;
  logic                   mi_pwrite_q, mi_pwrite_d;
  logic [P_MI_AW-1:0]     mi_paddr_q, mi_paddr_d;
  logic [C_APB_DW-1:0]    mi_pwdata_q, mi_pwdata_d;
  logic                   dead_q, dead_d;

  logic [P_SEL_W-1:0]     slot;
  logic [P_NUM_MI-1:0]    slot_oh;
  logic                   sel_rdy;
  logic                   sel_err;
  logic [C_APB_DW-1:0]    sel_rdata;
  logic                   unused_si;

  assign slot      = i_si_paddr[P_SEL_LSB +: P_SEL_W];
  // penable is not needed: a transfer is launched from psel alone
  assign unused_si = ^{i_si_penable, i_si_paddr};

`ifdef APB_DECO_TIMEOUT_EN
  logic tmo_expire;
  logic timeout_q, timeout_d;

  apb_deco_timer #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_timer (
    .clk    (i_clk_si),
    .rst    (i_rst_si),
    .start  (state_q == ST_SETUP),
    .run    (state_q == ST_ACCESS),
    .expire (tmo_expire)
  );

  assign o_timeout = timeout_q;
`else
  localparam int C_UNUSED_TIMEOUT = P_TIMEOUT;
  assign o_timeout = 1'b0;
`endif

  // One-hot decode of the incoming slot; unmapped slots decode to all-zero
  always_comb begin
    slot_oh = '0;
    for (int k = 0; k < P_NUM_MI; k++) begin
      slot_oh[k] = (int'(slot) == k);
    end
  end

  // Per-port return mux steered by the registered select, so idle ports are ignored
  always_comb begin
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < P_NUM_MI; k++) begin
      if (mi_psel_q[k]) begin
        sel_rdy   = sel_rdy | i_mi_pready[k];
        sel_err   = sel_err | i_mi_pslverr[k];
        sel_rdata = sel_rdata | i_mi_prdata[C_APB_DW*k +: C_APB_DW];
      end
    end
  end

  // FSM next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    si_prdata_d  = '0;
    si_pready_d  = 1'b0;
    si_pslverr_d = 1'b0;
    mi_psel_d    = mi_psel_q;
    mi_penable_d = mi_penable_q;
    mi_pwrite_d  = mi_pwrite_q;
    mi_paddr_d   = mi_paddr_q;
    mi_pwdata_d  = mi_pwdata_q;
    dead_d       = 1'b0;
`ifdef APB_DECO_TIMEOUT_EN
    timeout_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // dead_q blocks the cycle right after RESP while the SI finishes its transfer
        if (i_si_psel && !si_pready_q && !dead_q) begin
          mi_pwrite_d = i_si_pwrite;
          mi_paddr_d  = i_si_paddr[P_MI_AW-1:0];
          mi_pwdata_d = i_si_pwdata;
          if (f_slot_valid(int'(slot), P_NUM_MI)) begin
            state_d      = ST_SETUP;
            mi_psel_d    = slot_oh;
            mi_penable_d = 1'b0;
          end else begin
            state_d      = ST_RESP;
            si_pready_d  = 1'b1;
            si_pslverr_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d      = ST_ACCESS;
        mi_penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_rdy) begin
          state_d      = ST_RESP;
          si_pready_d  = 1'b1;
          si_pslverr_d = sel_err;
          si_prdata_d  = mi_pwrite_q ? '0 : sel_rdata;
          mi_psel_d    = '0;
          mi_penable_d = 1'b0;
`ifdef APB_DECO_TIMEOUT_EN
        end else if (tmo_expire) begin
          state_d      = ST_RESP;
          si_pready_d  = 1'b1;
          si_pslverr_d = 1'b1;
          mi_psel_d    = '0;
          mi_penable_d = 1'b0;
          timeout_d    = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        dead_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without a response
  always_ff @(posedge i_clk_si) begin
    if (i_rst_si) begin
      state_q      <= ST_IDLE;
      si_prdata_q  <= '0;
      si_pready_q  <= 1'b0;
      si_pslverr_q <= 1'b0;
      mi_psel_q    <= '0;
      mi_penable_q <= 1'b0;
      mi_pwrite_q  <= 1'b0;
      mi_paddr_q   <= '0;
      mi_pwdata_q  <= '0;
      dead_q       <= 1'b0;
`ifdef APB_DECO_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      si_prdata_q  <= si_prdata_d;
      si_pready_q  <= si_pready_d;
      si_pslverr_q <= si_pslverr_d;
      mi_psel_q    <= mi_psel_d;
      mi_penable_q <= mi_penable_d;
      mi_pwrite_q  <= mi_pwrite_d;
      mi_paddr_q   <= mi_paddr_d;
      mi_pwdata_q  <= mi_pwdata_d;
      dead_q       <= dead_d;
`ifdef APB_DECO_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign o_si_prdata  = si_prdata_q;
  assign o_si_pready  = si_pready_q;
  assign o_si_pslverr = si_pslverr_q;
  assign o_mi_psel    = mi_psel_q;
  assign o_mi_penable = mi_penable_q;
  assign o_mi_pwrite  = mi_pwrite_q;
  assign o_mi_paddr   = mi_paddr_q;
  assign o_mi_pwdata  = mi_pwdata_q;

endmodule

// File: tb/tb_apb3_deco_nport.sv
// tb/tb_apb3_deco_nport.sv - scoreboard bench for apb3_deco_nport; timeout cases under APB_DECO_TIMEOUT_EN
module tb_apb3_deco_nport;

  localparam int NMI = 5;

  logic            clk = 1'b0;
  logic            rst_si;
  logic            si_psel;
  logic            si_penable;
  logic            si_pwrite;
  logic [31:0]     si_paddr;
  logic [31:0]     si_pwdata;
  logic [31:0]     o_si_prdata;
  logic            o_si_pready;
  logic            o_si_pslverr;
  logic [NMI-1:0]  o_mi_psel;
  logic            o_mi_penable;
  logic            o_mi_pwrite;
  logic [11:0]     o_mi_paddr;
  logic [31:0]     o_mi_pwdata;
  logic [NMI*32-1:0] i_mi_prdata;
  logic [NMI-1:0]  i_mi_pready;
  logic [NMI-1:0]  i_mi_pslverr;
  logic            o_timeout;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          start_cyc = 0;
  int          acc_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          mi_wait[NMI];
  logic [31:0] mi_rdata[NMI];
  logic        mi_err[NMI];

  apb3_deco_nport #(
    .P_NUM_MI  (NMI),
    .P_SEL_LSB (12),
    .P_SEL_W   (4),
    .P_MI_AW   (12),
    .P_TIMEOUT (8)
  ) dut (
    .i_clk_si     (clk),
    .i_rst_si     (rst_si),
    .i_si_psel    (si_psel),
    .i_si_penable (si_penable),
    .i_si_pwrite  (si_pwrite),
    .i_si_paddr   (si_paddr),
    .i_si_pwdata  (si_pwdata),
    .o_si_prdata  (o_si_prdata),
    .o_si_pready  (o_si_pready),
    .o_si_pslverr (o_si_pslverr),
    .o_mi_psel    (o_mi_psel),
    .o_mi_penable (o_mi_penable),
    .o_mi_pwrite  (o_mi_pwrite),
    .o_mi_paddr   (o_mi_paddr),
    .o_mi_pwdata  (o_mi_pwdata),
    .i_mi_prdata  (i_mi_prdata),
    .i_mi_pready  (i_mi_pready),
    .i_mi_pslverr (i_mi_pslverr),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc_cnt <= o_mi_penable ? acc_cnt + 1 : 0;
  end

  // MI models: selected port follows its wait/data/err setup; idle ports drive hostile values
  always_comb begin
    i_mi_pready  = '0;
    i_mi_pslverr = '0;
    i_mi_prdata  = '0;
    for (int k = 0; k < NMI; k++) begin
      if (o_mi_psel[k]) begin
        i_mi_pready[k]        = o_mi_penable && (acc_cnt >= mi_wait[k]);
        i_mi_pslverr[k]       = mi_err[k];
        i_mi_prdata[32*k +: 32] = mi_rdata[k];
      end else begin
        i_mi_pready[k]        = 1'b1;
        i_mi_pslverr[k]       = 1'b1;
        i_mi_prdata[32*k +: 32] = 32'hBAD0_0000 | k;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response monitor: pop the scoreboard on every SI ready pulse
  always @(negedge clk) begin
    if (rst_si === 1'b0) begin
      if (o_si_pready) begin
        check_eq("resp_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_eq("resp_rdata", o_si_prdata, mon_e.rdata);
          check_eq("resp_err", o_si_pslverr, mon_e.err);
          check_eq("resp_latency", cyc - start_cyc, mon_e.lat);
          check_eq("resp_timeout", o_timeout, mon_e.tmo);
        end
      end else begin
        check_eq("idle_si_outs", {o_si_prdata, o_si_pslverr, o_timeout}, '0);
      end
    end
  end

  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [31:0] x_rdata, input logic x_err, input int x_lat,
                         input logic x_tmo, input bit drop);
    exp_t        e;
    int          slot;
    logic [4:0]  oh;
    bit          seen;
    e.rdata = x_rdata;
    e.err   = x_err;
    e.lat   = x_lat;
    e.tmo   = x_tmo;
    sb_q.push_back(e);
    slot = int'(addr[15:12]);
    oh   = (slot < NMI) ? 5'(1 << slot) : 5'd0;
    @(negedge clk);
    si_psel    = 1'b1;
    si_penable = 1'b0;
    si_pwrite  = wr;
    si_paddr   = addr;
    si_pwdata  = wdata;
    start_cyc  = cyc;
    @(negedge clk);
    check_eq("setup_bus", {o_mi_psel, o_mi_penable, o_mi_pwrite, o_mi_paddr, o_mi_pwdata},
             {oh, 1'b0, wr, addr[11:0], wdata});
    seen = o_si_pready;
    si_penable = 1'b1;
    if (!seen) begin
      @(negedge clk);
      check_eq("access_sel", {o_mi_psel, o_mi_penable}, {oh, 1'b1});
      if (drop) begin
        si_psel    = 1'b0;
        si_penable = 1'b0;
      end
      seen = o_si_pready;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = o_si_pready;
    end
    check_eq("resp_seen", seen, 1);
    if (!seen) sb_q.delete();
    @(negedge clk);
    si_psel    = 1'b0;
    si_penable = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NMI; k++) begin
      mi_wait[k]  = 0;
      mi_rdata[k] = 32'h0;
      mi_err[k]   = 1'b0;
    end
    rst_si     = 1'b1;
    si_psel    = 1'b0;
    si_penable = 1'b0;
    si_pwrite  = 1'b0;
    si_paddr   = '0;
    si_pwdata  = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", {o_si_prdata, o_si_pready, o_si_pslverr, o_mi_psel, o_mi_penable,
             o_mi_pwrite, o_mi_paddr, o_mi_pwdata, o_timeout}, '0);
    rst_si = 1'b0;

    do_xfer(32'h0000_2010, 1'b1, 32'hA5A5_0001, 32'h0, 1'b0, 3, 1'b0, 1'b0);

    mi_wait[4]  = 2;
    mi_rdata[4] = 32'hDEAD_BEEF;
    do_xfer(32'h0000_4004, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b0, 1'b0);

    do_xfer(32'h0000_7000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
    do_xfer(32'h0000_5000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
    do_xfer(32'h0000_F004, 1'b1, 32'h1, 32'h0, 1'b1, 1, 1'b0, 1'b0);

    mi_err[1]   = 1'b1;
    mi_rdata[1] = 32'h7777_7777;
    do_xfer(32'h0000_1008, 1'b1, 32'h0000_00FF, 32'h0, 1'b1, 3, 1'b0, 1'b0);
    mi_err[1]   = 1'b0;
    mi_rdata[1] = 32'h1111_2222;
    do_xfer(32'h0000_100C, 1'b0, 32'h0, 32'h1111_2222, 1'b0, 3, 1'b0, 1'b0);

    mi_rdata[0] = 32'h1234_5678;
    do_xfer(32'h0000_0FFC, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0, 1'b0);

    mi_wait[3]  = 1;
    mi_rdata[3] = 32'hCAFE_0003;
    do_xfer(32'hFFFF_3ABC, 1'b0, 32'h0, 32'hCAFE_0003, 1'b0, 4, 1'b0, 1'b0);

    mi_wait[2]  = 3;
    mi_rdata[2] = 32'h0000_5A5A;
    do_xfer(32'h0000_2020, 1'b0, 32'h0, 32'h0000_5A5A, 1'b0, 6, 1'b0, 1'b1);

    // Reset held for three cycles in the middle of a stalled ACCESS
    mi_wait[4] = 100;
    @(negedge clk);
    si_psel  = 1'b1;
    si_pwrite = 1'b0;
    si_paddr = 32'h0000_4000;
    @(negedge clk);
    si_penable = 1'b1;
    @(negedge clk);
    check_eq("pre_reset_access", {o_mi_psel, o_mi_penable}, {5'b10000, 1'b1});
    rst_si = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_outs", {o_si_prdata, o_si_pready, o_si_pslverr, o_mi_psel, o_mi_penable,
               o_mi_pwrite, o_mi_paddr, o_mi_pwdata, o_timeout}, '0);
    end
    si_psel    = 1'b0;
    si_penable = 1'b0;
    rst_si     = 1'b0;
    @(negedge clk);
    check_eq("post_reset_quiet", {o_si_pready, o_mi_psel, o_mi_penable}, '0);
    mi_wait[4]  = 0;
    mi_rdata[4] = 32'h4444_0000;
    do_xfer(32'h0000_4010, 1'b0, 32'h0, 32'h4444_0000, 1'b0, 3, 1'b0, 1'b0);

`ifdef APB_DECO_TIMEOUT_EN
    mi_wait[0] = 1000;
    do_xfer(32'h0000_0100, 1'b0, 32'h0, 32'h0, 1'b1, 10, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    mi_wait[0]  = 7;
    mi_rdata[0] = 32'h0BAD_CAFE;
    do_xfer(32'h0000_0104, 1'b0, 32'h0, 32'h0BAD_CAFE, 1'b0, 10, 1'b0, 1'b0);
    mi_wait[0]  = 6;
    do_xfer(32'h0000_0108, 1'b0, 32'h0, 32'h0BAD_CAFE, 1'b0, 9, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
